// File: rtl/fifo_mem_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_mem_writer_pkg
//  Purpose  : Shared state encoding and FIFO handshake widths for the
//             result-FIFO drain stage.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_mem_writer_pkg;

  // Drain-stage control states; the encoding is fixed so that debug
  // taps and the fifo instance agree on it.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Handshake widths shared with the result FIFO instance.
  localparam int FIFO_DATA_WIDTH = 32;
  localparam int MEM_ADDR_WIDTH  = 32;
  localparam int XFER_LEN_WIDTH  = 16;

endpackage : fifo_mem_writer_pkg
`default_nettype wire

// File: rtl/fifo_mem_writer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_mem_writer
//  Purpose  : Drains the accelerator result FIFO into the memory write port,
//             one word per FETCH/WRITE pair, at base + n*stride.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_mem_writer
  import fifo_mem_writer_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int LEN_WIDTH  = XFER_LEN_WIDTH
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  startIn,
  input  logic [ADDR_WIDTH-1:0] baseAddrIn,
  input  logic [ADDR_WIDTH-1:0] strideIn,
  input  logic [LEN_WIDTH-1:0]  lenIn,
  input  logic                  abortIn,
  output logic                  busyOut,
  output logic                  doneOut,
  output logic [LEN_WIDTH-1:0]  countOut,
  input  logic [DATA_WIDTH-1:0] rdDataIn,
  input  logic                  rdValidIn,
  output logic                  rdReadyOut,
  output logic [ADDR_WIDTH-1:0] memAddrOut,
  output logic [DATA_WIDTH-1:0] memDataOut,
  output logic                  memWrOut,
  input  logic                  memAckIn
);

  state_t                stateR;
  logic [ADDR_WIDTH-1:0] addrR;
  logic [ADDR_WIDTH-1:0] strideR;
  logic [LEN_WIDTH-1:0]  lenR;
  logic                  abortR;
  logic [LEN_WIDTH-1:0]  countInc;

  // Count after the word currently in WRITE is acknowledged.
  assign countInc = countOut + LEN_WIDTH'(1);

  // The FIFO is only drained while waiting for the next word.
  assign rdReadyOut = (stateR == S_FETCH);

  // Control FSM with registered outputs and the address/count datapath.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      stateR     <= S_IDLE;
      addrR      <= '0;
      strideR    <= '0;
      lenR       <= '0;
      abortR     <= 1'b0;
      busyOut    <= 1'b0;
      doneOut    <= 1'b0;
      countOut   <= '0;
      memAddrOut <= '0;
      memDataOut <= '0;
      memWrOut   <= 1'b0;
    end else begin
      case (stateR)
        S_IDLE: begin
          doneOut <= 1'b0;
          if (startIn) begin
            strideR  <= strideIn;
            lenR     <= lenIn;
            addrR    <= baseAddrIn;
            countOut <= '0;
            abortR   <= 1'b0;
            busyOut  <= 1'b1;
            if (lenIn == '0) begin
              // Empty transfer completes straight away.
              stateR  <= S_DONE;
              doneOut <= 1'b1;
            end else begin
              stateR <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (abortIn) begin
            stateR  <= S_IDLE;
            busyOut <= 1'b0;
          end else if (rdValidIn) begin
            memDataOut <= rdDataIn;
            memAddrOut <= addrR;
            memWrOut   <= 1'b1;
            stateR     <= S_WRITE;
          end
        end

        S_WRITE: begin
          // An abort here cannot cancel the write already presented, so it
          // is remembered until the ack arrives.
          if (abortIn) begin
            abortR <= 1'b1;
          end
          if (memAckIn) begin
            memWrOut <= 1'b0;
            countOut <= countInc;
            addrR    <= addrR + strideR;
            if (abortR || abortIn) begin
              stateR  <= S_IDLE;
              busyOut <= 1'b0;
              abortR  <= 1'b0;
            end else if (countInc == lenR) begin
              stateR  <= S_DONE;
              doneOut <= 1'b1;
            end else begin
              stateR <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          doneOut <= 1'b0;
          busyOut <= 1'b0;
          stateR  <= S_IDLE;
        end

        default: begin
          stateR  <= S_IDLE;
          busyOut <= 1'b0;
          doneOut <= 1'b0;
        end
      endcase
    end
  end

endmodule : fifo_mem_writer
`default_nettype wire

// File: tb/tb_fifo_mem_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_mem_writer
//  Purpose  : Self-checking bench for fifo_mem_writer against a queue-based
//             FIFO/memory reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_mem_writer;

  localparam int BUDGET = 400;

  logic        clkIn = 1'b0;
  logic        rstIn = 1'b0;
  logic        startIn = 1'b0;
  logic [31:0] baseAddrIn = '0;
  logic [31:0] strideIn = '0;
  logic [15:0] lenIn = '0;
  logic        abortIn = 1'b0;
  logic        busyOut;
  logic        doneOut;
  logic [15:0] countOut;
  logic [31:0] rdDataIn = '0;
  logic        rdValidIn = 1'b0;
  logic        rdReadyOut;
  logic [31:0] memAddrOut;
  logic [31:0] memDataOut;
  logic        memWrOut;
  logic        memAckIn = 1'b0;

  int passCnt = 0;
  int checkCnt = 0;
  logic [31:0] fifoQ[$];

  fifo_mem_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .startIn(startIn), .baseAddrIn(baseAddrIn),
    .strideIn(strideIn), .lenIn(lenIn), .abortIn(abortIn), .busyOut(busyOut),
    .doneOut(doneOut), .countOut(countOut), .rdDataIn(rdDataIn),
    .rdValidIn(rdValidIn), .rdReadyOut(rdReadyOut), .memAddrOut(memAddrOut),
    .memDataOut(memDataOut), .memWrOut(memWrOut), .memAckIn(memAckIn)
  );

  always #5 clkIn = ~clkIn;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One transfer: the FIFO contents in fifoQ are the data stream, and the
  // expected write n goes to base + n*stride with the n-th FIFO word.
  task automatic runXfer(input logic [31:0] base, input logic [31:0] stride, input int len,
                         input int ackDelay, input int emptyCyc, input int abortWord,
                         input string tag);
    logic [31:0] expData[$];
    logic [31:0] expAddr;
    logic [31:0] prevA;
    logic [31:0] prevD;
    int acked = 0;
    int reads = 0;
    int dones = 0;
    int waitCnt = 0;
    int cyc = 0;
    int rises = 0;
    int lastRise = -1;
    bit prevWr = 1'b0;
    bit abortSent = 1'b0;
    int expCount;
    expData = fifoQ;
    prevA = '0;
    prevD = '0;
    @(negedge clkIn);
    startIn = 1'b1; baseAddrIn = base; strideIn = stride; lenIn = 16'(len);
    @(negedge clkIn);
    startIn = 1'b0; baseAddrIn = $urandom; strideIn = $urandom; lenIn = 16'($urandom);
    check({tag, " busy after start"}, 64'(busyOut), 64'd1);
    while (busyOut && cyc < BUDGET) begin
      if (doneOut) dones++;
      abortIn = 1'b0;
      if (memWrOut) begin
        if (!prevWr) begin
          rises++;
          if (ackDelay == 0 && lastRise >= 0)
            check({tag, " word spacing"}, 64'(cyc - lastRise), 64'd2);
          lastRise = cyc;
          waitCnt = 0;
          expAddr = base + stride * 32'(acked);
          check({tag, " write addr"}, 64'(memAddrOut), 64'(expAddr));
          check({tag, " write data"}, 64'(memDataOut),
                (acked < expData.size()) ? 64'(expData[acked]) : 64'hDEAD);
        end else begin
          check({tag, " addr stable"}, 64'(memAddrOut), 64'(prevA));
          check({tag, " data stable"}, 64'(memDataOut), 64'(prevD));
        end
        check({tag, " no read while writing"}, 64'(rdReadyOut), 64'd0);
        prevA = memAddrOut;
        prevD = memDataOut;
        if (abortWord == acked + 1 && waitCnt == 0 && !abortSent) begin
          abortIn = 1'b1;
          abortSent = 1'b1;
        end
        memAckIn = (waitCnt >= ackDelay);
        waitCnt++;
        if (memAckIn) acked++;
      end else begin
        // Stray acks with no write pending must be ignored.
        memAckIn = 1'($urandom);
      end
      rdValidIn = (fifoQ.size() > 0) && (cyc >= emptyCyc);
      rdDataIn = rdValidIn ? fifoQ[0] : $urandom;
      if (cyc < emptyCyc && len > 0)
        check({tag, " ready while empty"}, 64'(rdReadyOut), 64'd1);
      if (rdValidIn && rdReadyOut) begin
        void'(fifoQ.pop_front());
        reads++;
      end
      prevWr = memWrOut;
      @(negedge clkIn);
      cyc++;
    end
    abortIn = 1'b0; memAckIn = 1'b0; rdValidIn = 1'b0;
    expCount = (abortWord > 0) ? abortWord : len;
    check({tag, " finished in budget"}, 64'(cyc < BUDGET), 64'd1);
    check({tag, " done pulses"}, 64'(dones), (abortWord > 0) ? 64'd0 : 64'd1);
    check({tag, " countOut"}, 64'(countOut), 64'(expCount));
    check({tag, " fifo reads"}, 64'(reads), 64'(expCount));
    check({tag, " writes"}, 64'(rises), 64'(expCount));
    check({tag, " memWr idle"}, 64'(memWrOut), 64'd0);
    fifoQ.delete();
  endtask

  initial begin
    int budget;
    // Reset state
    repeat (3) @(negedge clkIn);
    check("rst busy", 64'(busyOut), 64'd0);
    check("rst done", 64'(doneOut), 64'd0);
    check("rst ready", 64'(rdReadyOut), 64'd0);
    check("rst memWr", 64'(memWrOut), 64'd0);
    check("rst count", 64'(countOut), 64'd0);
    check("rst addr", 64'(memAddrOut), 64'd0);
    check("rst data", 64'(memDataOut), 64'd0);
    rstIn = 1'b1;

    fifoQ = {32'hA, 32'hB, 32'hC};
    runXfer(32'h1000, 32'd4, 3, 0, 0, 0, "basic");

    runXfer($urandom, $urandom, 0, 0, 0, 0, "len0");

    for (int i = 0; i < 3; i++) fifoQ.push_back($urandom);
    runXfer(32'h2000, 32'd8, 3, 3, 0, 0, "ackdelay");

    fifoQ = {32'h1234_5678};
    runXfer(32'h300, 32'd4, 1, 0, 10, 0, "emptyfifo");

    for (int i = 0; i < 4; i++) fifoQ.push_back($urandom);
    runXfer(32'h5000, 32'h10, 4, 2, 0, 2, "abort");

    for (int i = 0; i < 3; i++) fifoQ.push_back($urandom);
    runXfer(32'h4, 32'hFFFF_FFFC, 3, 1, 0, 0, "wrap");

    for (int i = 0; i < 5; i++) fifoQ.push_back($urandom);
    runXfer($urandom, 32'd0, 5, 1, 0, 0, "stride0");

    for (int t = 0; t < 3; t++) begin
      int n;
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) fifoQ.push_back($urandom);
      runXfer($urandom, $urandom, n, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 0, "random");
    end

    // Asynchronous reset while a write is pending
    @(negedge clkIn);
    startIn = 1'b1; baseAddrIn = 32'h8000; strideIn = 32'd4; lenIn = 16'd2;
    rdValidIn = 1'b1; rdDataIn = 32'hCAFE_F00D; memAckIn = 1'b0;
    @(negedge clkIn);
    startIn = 1'b0;
    budget = 0;
    while (!memWrOut && budget < 20) begin
      @(negedge clkIn);
      budget++;
    end
    rdValidIn = 1'b0;
    check("rstmid write pending", 64'(memWrOut), 64'd1);
    #2 rstIn = 1'b0;
    #1;
    check("rstmid memWr async", 64'(memWrOut), 64'd0);
    check("rstmid busy async", 64'(busyOut), 64'd0);
    check("rstmid count async", 64'(countOut), 64'd0);
    @(negedge clkIn);
    rstIn = 1'b1;
    @(negedge clkIn);
    check("rstmid idle after release", 64'(busyOut), 64'd0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule : tb_fifo_mem_writer
`default_nettype wire
